// File: rtl/dual_fifo_issue.sv
`default_nettype none
// ============================================================================
//  Module      : dual_fifo_issue
//  Description : Consumer end of the FIFO_1/FIFO_2 instruction path. Each of
//                the two lanes pops its FIFO, absorbs the one-cycle FIFO read
//                latency, and holds up to two instructions in a skid buffer.
//                The lane presents the oldest instruction over valid/ready and
//                can sustain one instruction per cycle.
//  Options     : ISSUE_COUNT_EN - adds per-lane wrapping issue counters
//                (lane1_issued_cnt / lane2_issued_cnt, CNT_W bits each).
//  Revision    : 1.0 - initial release
// ============================================================================
module dual_fifo_issue #(
  parameter int DATA_W    = 32,
  parameter int BUF_DEPTH = 2
`ifdef ISSUE_COUNT_EN
  ,
  parameter int CNT_W     = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              fifo1_empty,
  output logic              fifo1_rd_en,
  input  logic [DATA_W-1:0] fifo1_data,
  input  logic              fifo2_empty,
  output logic              fifo2_rd_en,
  input  logic [DATA_W-1:0] fifo2_data,
  output logic              lane1_valid,
  input  logic              lane1_ready,
  output logic [DATA_W-1:0] lane1_instr,
  output logic              lane2_valid,
  input  logic              lane2_ready,
  output logic [DATA_W-1:0] lane2_instr,
  output logic              idle
`ifdef ISSUE_COUNT_EN
  ,
  output logic [CNT_W-1:0]  lane1_issued_cnt,
  output logic [CNT_W-1:0]  lane2_issued_cnt
`endif
);

  // Skid capacity per lane; the buffer logic below is written for exactly two.
  localparam logic [2:0] c_depth = 3'(BUF_DEPTH);

  // Per-lane views of the two port sets so both lanes share one implementation.
  logic [1:0]        w_empty;
  logic [1:0]        w_ready;
  logic [1:0]        w_rd_en;
  logic [1:0]        w_valid;
  logic [1:0]        w_busy;
  logic [DATA_W-1:0] w_fdata [2];
  logic [DATA_W-1:0] w_instr [2];
`ifdef ISSUE_COUNT_EN
  logic [CNT_W-1:0]  w_cnt   [2];
`endif

  assign w_empty    = {fifo2_empty, fifo1_empty};
  assign w_ready    = {lane2_ready, lane1_ready};
  assign w_fdata[0] = fifo1_data;
  assign w_fdata[1] = fifo2_data;

  assign fifo1_rd_en = w_rd_en[0];
  assign fifo2_rd_en = w_rd_en[1];
  assign lane1_valid = w_valid[0];
  assign lane2_valid = w_valid[1];
  assign lane1_instr = w_instr[0];
  assign lane2_instr = w_instr[1];
`ifdef ISSUE_COUNT_EN
  assign lane1_issued_cnt = w_cnt[0];
  assign lane2_issued_cnt = w_cnt[1];
`endif

  // Idle only when neither lane holds or awaits an instruction; built purely
  // from registered state so it carries no input-to-output path.
  assign idle = ~|w_busy;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    logic [1:0]        r_occ;      // skid entries held, 0..2
    logic              r_infl;     // a FIFO read issued last cycle returns now
    logic [DATA_W-1:0] r_head;     // oldest entry, drives the lane directly
    logic [DATA_W-1:0] r_tail;     // second entry when two are held
    logic              w_deq;
    logic [2:0]        w_level;    // occupancy after this edge
    logic              w_shift;
    logic              w_load_head;
    logic              w_load_tail;

    assign w_valid[g] = (r_occ != 2'd0);
    assign w_deq      = w_valid[g] & w_ready[g];

    // Count the returning word and the departing one so a full buffer that is
    // being drained can still issue a read the same cycle.
    assign w_level    = {1'b0, r_occ} + {2'b00, r_infl} - {2'b00, w_deq};
    assign w_rd_en[g] = ~reset & ~flush & ~w_empty[g] & (w_level < c_depth);

    // Head takes the returning word when it would be the only entry; tail
    // takes it when the head is still occupied after this edge.
    assign w_shift     = w_deq & (r_occ == 2'd2);
    assign w_load_head = r_infl & ((r_occ == 2'd0) | ((r_occ == 2'd1) & w_deq));
    assign w_load_tail = r_infl & (((r_occ == 2'd1) & ~w_deq) | w_shift);

    assign w_busy[g]  = w_valid[g] | r_infl;
    assign w_instr[g] = r_head;

    // Occupancy and in-flight tracking; flush drops both held and returning data.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_occ  <= 2'd0;
        r_infl <= 1'b0;
      end else if (flush) begin
        r_occ  <= 2'd0;
        r_infl <= 1'b0;
      end else begin
        r_occ  <= w_level[1:0];
        r_infl <= w_rd_en[g];
      end
    end

    // Skid buffer storage; contents are don't-care once occupancy says empty.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_head <= '0;
        r_tail <= '0;
      end else if (!flush) begin
        if (w_load_head) begin
          r_head <= w_fdata[g];
        end else if (w_shift) begin
          r_head <= r_tail;
        end
        if (w_load_tail) begin
          r_tail <= w_fdata[g];
        end
      end
    end

    // A third entry can never be requested because reads are throttled.
    a_occ_bound: assert property (@(posedge clk) disable iff (reset)
                                  (w_level <= 3'd2));

`ifdef ISSUE_COUNT_EN
    logic [CNT_W-1:0] r_cnt;

    // Counts every accepted instruction; wraps naturally and survives flush.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_cnt <= '0;
      end else if (w_deq) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign w_cnt[g] = r_cnt;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_dual_fifo_issue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dual_fifo_issue
//  Description : Self-checking bench for dual_fifo_issue. Two FIFO models feed
//                the DUT; every word the FIFOs hand over is queued as expected
//                lane output, and a monitor compares lane activity against it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dual_fifo_issue;

  localparam int DW = 32;
`ifdef ISSUE_COUNT_EN
  localparam int CW = 4;
`endif

  logic          clk = 1'b0;
  logic          reset, flush;
  logic          fifo1_empty, fifo2_empty;
  logic          fifo1_rd_en, fifo2_rd_en;
  logic [DW-1:0] fifo1_data, fifo2_data;
  logic          lane1_valid, lane2_valid;
  logic          lane1_ready, lane2_ready;
  logic [DW-1:0] lane1_instr, lane2_instr;
  logic          idle;
`ifdef ISSUE_COUNT_EN
  logic [CW-1:0] lane1_issued_cnt, lane2_issued_cnt;
`endif

  always #5 clk = ~clk;

  dual_fifo_issue #(
    .DATA_W    (DW),
    .BUF_DEPTH (2)
`ifdef ISSUE_COUNT_EN
    ,
    .CNT_W     (CW)
`endif
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .fifo1_empty (fifo1_empty),
    .fifo1_rd_en (fifo1_rd_en),
    .fifo1_data  (fifo1_data),
    .fifo2_empty (fifo2_empty),
    .fifo2_rd_en (fifo2_rd_en),
    .fifo2_data  (fifo2_data),
    .lane1_valid (lane1_valid),
    .lane1_ready (lane1_ready),
    .lane1_instr (lane1_instr),
    .lane2_valid (lane2_valid),
    .lane2_ready (lane2_ready),
    .lane2_instr (lane2_instr),
    .idle        (idle)
`ifdef ISSUE_COUNT_EN
    ,
    .lane1_issued_cnt (lane1_issued_cnt),
    .lane2_issued_cnt (lane2_issued_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference state: FIFO contents, words expected at each lane, reads pending.
  logic [31:0] fq1[$], fq2[$];
  logic [31:0] eq1[$], eq2[$];
  logic [31:0] pend1, pend2;
  bit          infl1 = 0, infl2 = 0;
  bit          started = 0;
  int          cnt1 = 0, cnt2 = 0;
  int          rd1_cnt = 0, deq2_cnt = 0;

  task automatic push1(input logic [31:0] w);
    fq1.push_back(w);
    fifo1_empty = 1'b0;
  endtask

  task automatic push2(input logic [31:0] w);
    fq2.push_back(w);
    fifo2_empty = 1'b0;
  endtask

  // A read is allowed whenever the held words, the one returning and the one
  // leaving still leave room in a two-deep buffer.
  function automatic bit exp_rd(input bit rs, input bit fl, input bit emp,
                                input int held, input bit inf, input bit rdy);
    int leaving;
    leaving = (held > 0 && rdy) ? 1 : 0;
    return !rs && !fl && !emp && ((held + int'(inf) - leaving) < 2);
  endfunction

  // FIFO models: a pop at an edge delivers its word during the next cycle,
  // and that word joins the lane's expected stream at the following edge.
  always @(posedge clk) begin
    bit r1, r2, rs, fl;
    r1 = fifo1_rd_en;
    r2 = fifo2_rd_en;
    rs = reset;
    fl = flush;
    if (rs || fl) begin
      eq1.delete();
      eq2.delete();
    end else begin
      if (infl1) eq1.push_back(pend1);
      if (infl2) eq2.push_back(pend2);
    end
    if (rs) begin
      cnt1 = 0;
      cnt2 = 0;
    end
    infl1   = r1;
    infl2   = r2;
    started = 1;
    #1;
    if (r1 && fq1.size() > 0) begin
      pend1      = fq1.pop_front();
      fifo1_data = pend1;
    end else begin
      fifo1_data = $urandom;
    end
    fifo1_empty = (fq1.size() == 0);
    if (r2 && fq2.size() > 0) begin
      pend2      = fq2.pop_front();
      fifo2_data = pend2;
    end else begin
      fifo2_data = $urandom;
    end
    fifo2_empty = (fq2.size() == 0);
  end

  // Monitor: compares lane outputs with the expected streams every cycle.
  always @(negedge clk) begin
    if (started) begin
      check("rd_en1", fifo1_rd_en,
            exp_rd(reset, flush, fq1.size() == 0, eq1.size(), infl1, lane1_ready));
      check("rd_en2", fifo2_rd_en,
            exp_rd(reset, flush, fq2.size() == 0, eq2.size(), infl2, lane2_ready));
      check("valid1", lane1_valid, eq1.size() != 0);
      check("valid2", lane2_valid, eq2.size() != 0);
      if (eq1.size() != 0) check("instr1", lane1_instr, eq1[0]);
      if (eq2.size() != 0) check("instr2", lane2_instr, eq2[0]);
      check("idle", idle, eq1.size() == 0 && !infl1 && eq2.size() == 0 && !infl2);
`ifdef ISSUE_COUNT_EN
      check("cnt1", 32'(lane1_issued_cnt), 32'(cnt1 % 16));
      check("cnt2", 32'(lane2_issued_cnt), 32'(cnt2 % 16));
`endif
      if (fifo1_rd_en) rd1_cnt++;
      if (eq1.size() != 0 && lane1_ready) begin
        void'(eq1.pop_front());
        cnt1++;
      end
      if (eq2.size() != 0 && lane2_ready) begin
        void'(eq2.pop_front());
        cnt2++;
        deq2_cnt++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] pat;
    reset       = 1'b1;
    flush       = 1'b0;
    lane1_ready = 1'b0;
    lane2_ready = 1'b0;
    fifo1_empty = 1'b1;
    fifo2_empty = 1'b1;
    fifo1_data  = '0;
    fifo2_data  = '0;

    // Reset held two cycles with FIFO_1 non-empty.
    push1(32'h0000_0101);
    push1(32'h0000_0102);
    push1(32'h0000_0103);
    step(2);
    check("rst_rd_en1", fifo1_rd_en, 1'b0);
    check("rst_valid1", lane1_valid, 1'b0);
    check("rst_valid2", lane2_valid, 1'b0);
    check("rst_instr1", lane1_instr, 32'h0);
    check("rst_idle", idle, 1'b1);
    reset = 1'b0;
    #1;
    check("rd_after_rst", fifo1_rd_en, 1'b1);
    rd1_cnt = 0;

    // Latency / fill: lane 1 stalled, exactly two reads then hold.
    step(7);
    check("lat_rd_count", rd1_cnt, 2);
    check("lat_valid1", lane1_valid, 1'b1);
    check("lat_instr1", lane1_instr, 32'h0000_0101);

    // Throughput: eight back-to-back words on lane 2.
    lane2_ready = 1'b1;
    for (int i = 0; i < 8; i++) push2(32'h1000_0000 + i);
    deq2_cnt = 0;
    step(10);
    check("thru_deq2", deq2_cnt, 8);

    // Backpressure on lane 1 with lane 2 streaming in parallel.
    for (int i = 0; i < 6; i++) push1(32'h0000_0201 + i);
    for (int i = 0; i < 6; i++) push2(32'h2000_0000 + i);
    pat = 4'b1001;
    for (int i = 0; i < 16; i++) begin
      lane1_ready = pat[3 - (i % 4)];
      lane2_ready = 1'($urandom_range(0, 1));
      step(1);
    end
    lane1_ready = 1'b1;
    lane2_ready = 1'b1;
    step(12);
    check("bp_drained1", 32'(eq1.size() + fq1.size()), 32'd0);

    // Flush with lane 1 full and a lane 2 read in flight.
    lane1_ready = 1'b0;
    for (int i = 0; i < 4; i++) push1(32'h0000_0301 + i);
    step(5);
    check("pre_flush_valid1", lane1_valid, 1'b1);
    push2(32'h3000_0000);
    step(1);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    #1;
    check("flush_valid1", lane1_valid, 1'b0);
    check("flush_valid2", lane2_valid, 1'b0);
    check("flush_idle", idle, 1'b1);
    step(2);
    check("post_flush_valid1", lane1_valid, 1'b1);
    check("post_flush_instr1", lane1_instr, 32'h0000_0303);
    lane1_ready = 1'b1;
    step(6);

    // Randomized traffic with occasional flush.
    for (int i = 0; i < 400; i++) begin
      lane1_ready = ($urandom_range(0, 3) != 0);
      lane2_ready = ($urandom_range(0, 2) != 0);
      if (fq1.size() < 5 && $urandom_range(0, 1) == 1) push1($urandom);
      if (fq2.size() < 5 && $urandom_range(0, 1) == 1) push2($urandom);
      flush = ($urandom_range(0, 49) == 0);
      step(1);
    end
    flush       = 1'b0;
    lane1_ready = 1'b1;
    lane2_ready = 1'b1;
    step(15);

`ifdef ISSUE_COUNT_EN
    // Counter wrap, flush persistence and reset clear.
    lane2_ready = 1'b0;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    for (int i = 0; i < 17; i++) push1(32'h0000_0400 + i);
    step(25);
    check("cnt_wrap", 32'(lane1_issued_cnt), 32'd1);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    #1;
    check("cnt_flush_keep", 32'(lane1_issued_cnt), 32'd1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("cnt_reset", 32'(lane1_issued_cnt), 32'd0);
    step(2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
`default_nettype wire
